// File: rtl/wbi2c_pkg.sv
// Shared constants for the Wishbone I2C master: register map, CMD/STATUS bit
// positions, sequencer states and the bit-engine line-drive table.
package wbi2c_pkg;
  localparam logic [2:0] A_PRER_LO = 3'd0;
  localparam logic [2:0] A_PRER_HI = 3'd1;
  localparam logic [2:0] A_CTRL    = 3'd2;
  localparam logic [2:0] A_DATA    = 3'd3;
  localparam logic [2:0] A_CMD     = 3'd4;

  localparam int CTRL_EN  = 7;
  localparam int CMD_STA  = 7;
  localparam int CMD_STO  = 6;
  localparam int CMD_RD   = 5;
  localparam int CMD_WR   = 4;
  localparam int CMD_ACK  = 3;
  localparam int ST_RXACK = 7;
  localparam int ST_BUSY  = 6;
  localparam int ST_TIP   = 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_WRITE, S_READ, S_ACK, S_STOP} state_e;
  typedef enum logic [1:0] {OP_START, OP_STOP, OP_BIT} op_e;

  // Returns {scl_oe, sda_oe} for a given step and phase; din=1 releases SDA.
  function automatic logic [1:0] line_drive(op_e op, logic [1:0] ph, logic din);
    logic [1:0] d;
    d = 2'b00;
    case (op)
      OP_START: d = (ph == 2'd3) ? 2'b11 : (ph == 2'd2) ? 2'b01 : 2'b00;
      OP_STOP:  d = (ph == 2'd0) ? 2'b11 : (ph == 2'd1) ? 2'b01 : 2'b00;
      default:  d = {(ph == 2'd0) || (ph == 2'd3), ~din};
    endcase
    return d;
  endfunction
endpackage

// File: rtl/wbi2c_bit_engine.sv
// Executes one START, STOP or data bit as four prescaled phases, honouring
// slave clock stretching in phase 1 and sampling SDA at the end of phase 2.
module wbi2c_bit_engine
  import wbi2c_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  input  logic [15:0] i_prer,
  input  logic        i_start,
  input  op_e         i_op,
  input  logic        i_din,
  input  logic        i_scl,
  input  logic        i_sda,
  output logic        o_done,
  output logic        o_dout,
  output logic        o_scl_oe,
  output logic        o_sda_oe
);
  logic        r_busy;
  op_e         r_op;
  logic        r_din;
  logic [1:0]  r_phase;
  logic [15:0] r_cnt;
  logic        r_dout;
  logic        r_scl_oe;
  logic        r_sda_oe;
  logic        w_hold;
  logic        w_tick;

  assign w_hold   = (r_phase == 2'd1) & ~i_scl;
  assign w_tick   = r_busy & ~w_hold & (r_cnt == i_prer);
  assign o_done   = w_tick & (r_phase == 2'd3);
  assign o_dout   = r_dout;
  assign o_scl_oe = r_scl_oe;
  assign o_sda_oe = r_sda_oe;

  // Line drives are registered from the next phase so they change on the
  // same edge the phase does.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy   <= 1'b0;
      r_op     <= OP_BIT;
      r_din    <= 1'b1;
      r_phase  <= 2'd0;
      r_cnt    <= 16'd0;
      r_dout   <= 1'b0;
      r_scl_oe <= 1'b0;
      r_sda_oe <= 1'b0;
    end else if (!i_en) begin
      r_busy   <= 1'b0;
      r_phase  <= 2'd0;
      r_cnt    <= 16'd0;
      r_scl_oe <= 1'b0;
      r_sda_oe <= 1'b0;
    end else if (i_start) begin
      r_busy                 <= 1'b1;
      r_op                   <= i_op;
      r_din                  <= i_din;
      r_phase                <= 2'd0;
      r_cnt                  <= 16'd0;
      {r_scl_oe, r_sda_oe}   <= line_drive(i_op, 2'd0, i_din);
    end else if (o_done) begin
      r_busy <= 1'b0;
    end else if (w_tick) begin
      r_phase                <= r_phase + 2'd1;
      r_cnt                  <= 16'd0;
      {r_scl_oe, r_sda_oe}   <= line_drive(r_op, r_phase + 2'd1, r_din);
      if (r_phase == 2'd2) r_dout <= i_sda;
    end else if (r_busy) begin
      r_cnt <= w_hold ? 16'd0 : r_cnt + 16'd1;
    end
  end
endmodule

// File: rtl/wbi2c_master.sv
// Wishbone register file and byte sequencer for the I2C master; the bit
// engine below does the actual line timing.
module wbi2c_master
  import wbi2c_pkg::*;
#(
  parameter int          ADDR_WIDTH       = 28,
  parameter logic [15:0] DEFAULT_PRESCALE = 16'd49
) (
  input  logic                  i_clk,
  input  logic                  i_axi_reset_n,
  input  logic                  i_wb_cyc,
  input  logic                  i_wb_stb,
  input  logic                  i_wb_we,
  input  logic [ADDR_WIDTH-1:0] i_wb_addr,
  input  logic [7:0]            i_wb_data,
  input  logic                  i_wb_sel,
  output logic                  o_wb_stall,
  output logic                  o_wb_ack,
  output logic                  o_wb_err,
  output logic [7:0]            o_wb_data,
  input  logic                  i_scl,
  output logic                  o_scl_oe,
  input  logic                  i_sda,
  output logic                  o_sda_oe
);
  logic [7:0] r_prer_lo, r_prer_hi, r_txr, r_rxr, r_rdata;
  logic       r_en, r_rxack, r_busy, r_tip, r_ack, r_err;
  logic       r_sto, r_rd, r_wr, r_nack;
  state_e     r_state;
  logic [2:0] r_bit;

  logic [2:0] w_a;
  logic       w_req, w_map, w_wr, w_cmd_go, w_done, w_dout, w_start, w_din;
  logic       w_unused;
  state_e     w_nxt;
  logic [2:0] w_nxt_bit;
  op_e        w_op;

  assign w_a        = i_wb_addr[2:0];
  assign w_unused   = ^i_wb_addr[ADDR_WIDTH-1:3];
  assign w_req      = i_wb_cyc & i_wb_stb;
  assign w_map      = (w_a <= A_CMD);
  assign w_wr       = w_req & i_wb_we & i_wb_sel & w_map;
  assign w_cmd_go   = w_wr & (w_a == A_CMD) & r_en & ~r_tip & (|i_wb_data[7:4]);
  assign o_wb_stall = 1'b0;
  assign o_wb_ack   = r_ack;
  assign o_wb_err   = r_err;
  assign o_wb_data  = r_rdata;

  // Next step is chosen combinationally so the engine chains steps with no gap.
  always_comb begin
    w_nxt     = r_state;
    w_nxt_bit = r_bit;
    w_start   = 1'b0;
    if (w_cmd_go) begin
      w_start   = 1'b1;
      w_nxt_bit = 3'd7;
      if (i_wb_data[CMD_STA])     w_nxt = S_START;
      else if (i_wb_data[CMD_WR]) w_nxt = S_WRITE;
      else if (i_wb_data[CMD_RD]) w_nxt = S_READ;
      else                        w_nxt = S_STOP;
    end else if (w_done) begin
      case (r_state)
        S_START: w_nxt = r_wr ? S_WRITE : r_rd ? S_READ : r_sto ? S_STOP : S_IDLE;
        S_WRITE, S_READ: begin
          if (r_bit == 3'd0) w_nxt = S_ACK;
          else               w_nxt_bit = r_bit - 3'd1;
        end
        S_ACK:   w_nxt = r_sto ? S_STOP : S_IDLE;
        default: w_nxt = S_IDLE;
      endcase
      w_start = (w_nxt != S_IDLE);
    end
  end

  always_comb begin
    w_op  = OP_BIT;
    w_din = 1'b1;
    case (w_nxt)
      S_START: w_op  = OP_START;
      S_STOP:  w_op  = OP_STOP;
      S_WRITE: w_din = r_txr[w_nxt_bit];
      S_ACK:   w_din = r_rd ? r_nack : 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_axi_reset_n) begin
    if (!i_axi_reset_n) begin
      r_prer_lo <= DEFAULT_PRESCALE[7:0];
      r_prer_hi <= DEFAULT_PRESCALE[15:8];
      r_txr     <= 8'd0;
      r_rxr     <= 8'd0;
      r_rdata   <= 8'd0;
      r_en      <= 1'b0;
      r_rxack   <= 1'b0;
      r_busy    <= 1'b0;
      r_tip     <= 1'b0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_sto     <= 1'b0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_nack    <= 1'b0;
      r_state   <= S_IDLE;
      r_bit     <= 3'd0;
    end else begin
      r_ack   <= w_req & w_map;
      r_err   <= w_req & ~w_map;
      r_rdata <= 8'd0;
      if (w_req & w_map & ~i_wb_we) begin
        case (w_a)
          A_PRER_LO: r_rdata <= r_prer_lo;
          A_PRER_HI: r_rdata <= r_prer_hi;
          A_CTRL:    r_rdata <= {r_en, 7'd0};
          A_DATA:    r_rdata <= r_rxr;
          default:   r_rdata <= {r_rxack, r_busy, 4'd0, r_tip, 1'b0};
        endcase
      end
      if (w_wr) begin
        case (w_a)
          A_PRER_LO: if (!r_en) r_prer_lo <= i_wb_data;
          A_PRER_HI: if (!r_en) r_prer_hi <= i_wb_data;
          A_CTRL:    r_en  <= i_wb_data[CTRL_EN];
          A_DATA:    r_txr <= i_wb_data;
          default:   ;
        endcase
      end
      if (!r_en) begin
        r_state <= S_IDLE;
        r_tip   <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        r_state <= w_nxt;
        r_bit   <= w_nxt_bit;
        if (w_cmd_go) begin
          r_tip  <= 1'b1;
          r_sto  <= i_wb_data[CMD_STO];
          r_wr   <= i_wb_data[CMD_WR];
          r_rd   <= i_wb_data[CMD_RD] & ~i_wb_data[CMD_WR];
          r_nack <= i_wb_data[CMD_ACK];
        end else if (w_done && w_nxt == S_IDLE) begin
          r_tip <= 1'b0;
        end
        if (w_start && w_nxt == S_START) r_busy <= 1'b1;
        if (w_done && r_state == S_STOP) r_busy <= 1'b0;
        if (w_done && r_state == S_READ) r_rxr <= {r_rxr[6:0], w_dout};
        if (w_done && r_state == S_ACK && !r_rd) r_rxack <= w_dout;
      end
    end
  end

  wbi2c_bit_engine u_bit (
    .i_clk    (i_clk),
    .i_rst_n  (i_axi_reset_n),
    .i_en     (r_en),
    .i_prer   ({r_prer_hi, r_prer_lo}),
    .i_start  (w_start),
    .i_op     (w_op),
    .i_din    (w_din),
    .i_scl    (i_scl),
    .i_sda    (i_sda),
    .o_done   (w_done),
    .o_dout   (w_dout),
    .o_scl_oe (o_scl_oe),
    .o_sda_oe (o_sda_oe)
  );
endmodule

// File: tb/tb_wbi2c_master.sv
// Directed bench for wbi2c_master with an open-drain bus and a simple slave
// that drives a preset bit pattern per slot and can stretch SCL once.
module tb_wbi2c_master;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, sel = 1'b1;
  logic [27:0] addr = '0;
  logic [7:0]  wdat = '0;
  logic        stall, ack, err;
  logic [7:0]  rdat;
  logic        scl_oe, sda_oe, scl_line, sda_line;

  logic [8:0]  slv_bits = 9'h1FF;
  logic        slv_clr = 1'b0, stretch_arm = 1'b0;
  logic [3:0]  rises = '0, cur = '0;
  logic [8:0]  cap = '0;
  logic        prev_scl = 1'b0, slv_hold = 1'b0, hold_done = 1'b0;
  logic        sda_ref = 1'b0, sda_chg = 1'b0, slv_low;
  int          hcnt = 0;
  int          n_pass = 0, n_tot = 0;

  always #5 clk = ~clk;

  assign slv_low  = (cur <= 4'd8) ? ~slv_bits[4'd8 - cur] : 1'b0;
  assign scl_line = ~scl_oe & ~slv_hold;
  assign sda_line = ~sda_oe & ~slv_low;

  wbi2c_master #(.ADDR_WIDTH(28), .DEFAULT_PRESCALE(16'd49)) dut (
    .i_clk(clk), .i_axi_reset_n(rst_n),
    .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_addr(addr),
    .i_wb_data(wdat), .i_wb_sel(sel),
    .o_wb_stall(stall), .o_wb_ack(ack), .o_wb_err(err), .o_wb_data(rdat),
    .i_scl(scl_line), .o_scl_oe(scl_oe), .i_sda(sda_line), .o_sda_oe(sda_oe)
  );

  // Slave model: SCL rise captures the line, SCL fall advances the slot.
  always @(negedge clk) begin
    prev_scl <= scl_oe;
    if (slv_clr) begin
      rises <= '0; cur <= '0; cap <= '0; slv_hold <= 1'b0;
      hold_done <= 1'b0; sda_chg <= 1'b0; hcnt <= 0;
    end else begin
      if (prev_scl && !scl_oe) begin
        if (rises <= 4'd8) cap[4'd8 - rises] <= sda_line;
        if (rises != 4'd15) rises <= rises + 4'd1;
      end
      if (!prev_scl && scl_oe) cur <= rises;
      if (stretch_arm && !hold_done && !slv_hold && rises == 4'd4 && scl_oe) slv_hold <= 1'b1;
      if (slv_hold && !scl_oe) begin
        if (hcnt == 0) sda_ref <= sda_oe;
        else if (sda_oe !== sda_ref) sda_chg <= 1'b1;
        if (hcnt == 30) begin slv_hold <= 1'b0; hold_done <= 1'b1; end
        else hcnt <= hcnt + 1;
      end
    end
  end

  task automatic wb_write(input logic [2:0] a, input logic [7:0] d, input logic s);
    cyc = 1; stb = 1; we = 1; addr = {25'd0, a}; wdat = d; sel = s;
    @(posedge clk); #1;
    cyc = 0; stb = 0; we = 0; sel = 1;
  endtask

  task automatic wb_read(input logic [2:0] a, output logic [7:0] d, output logic k, output logic e);
    cyc = 1; stb = 1; we = 0; addr = {25'h1ABCDE0, a};
    @(posedge clk); #1;
    d = rdat; k = ack; e = err;
    cyc = 0; stb = 0;
  endtask

  // Back-to-back STATUS reads; counts acked reads showing TIP=1.
  task automatic poll_tip(output int n);
    n = 0;
    cyc = 1; stb = 1; we = 0; addr = 28'd4;
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk); #1;
      if (ack && rdat[1]) n++;
      else break;
    end
    cyc = 0; stb = 0;
  endtask

  task automatic slv_arm(input logic [8:0] b, input logic st);
    slv_bits = b; stretch_arm = st; slv_clr = 1;
    @(posedge clk); #1;
    slv_clr = 0;
  endtask

  task automatic test_reset;
    logic [7:0] d; logic k, e;
    repeat (3) @(posedge clk); #1;
    n_tot++; if ({scl_oe, sda_oe} !== 2'b00) $display("FAIL reset_oe got %b want 00", {scl_oe, sda_oe}); else n_pass++;
    n_tot++; if ({ack, err, rdat} !== 10'd0) $display("FAIL reset_wb got %h want 000", {ack, err, rdat}); else n_pass++;
    @(negedge clk); rst_n = 1;
    wb_read(3'd0, d, k, e);
    n_tot++; if ({k, d} !== 9'h131) $display("FAIL reset_prer_lo got %h want 131", {k, d}); else n_pass++;
    wb_read(3'd1, d, k, e);
    n_tot++; if (d !== 8'h00) $display("FAIL reset_prer_hi got %h want 00", d); else n_pass++;
    wb_read(3'd4, d, k, e);
    n_tot++; if (d !== 8'h00) $display("FAIL reset_status got %h want 00", d); else n_pass++;
  endtask

  task automatic test_write_byte;
    logic [7:0] d; logic k, e; int n;
    wb_write(3'd0, 8'd4, 1); wb_write(3'd1, 8'd0, 1);
    wb_write(3'd2, 8'h80, 1); wb_write(3'd3, 8'hA5, 1);
    slv_arm(9'h1FE, 0);
    wb_write(3'd4, 8'h90, 1);
    poll_tip(n);
    n_tot++; if (n != 200) $display("FAIL wr_tip_clocks got %0d want 200", n); else n_pass++;
    n_tot++; if (cap !== 9'h14A) $display("FAIL wr_sda_pattern got %h want 14a", cap); else n_pass++;
    wb_read(3'd4, d, k, e);
    n_tot++; if (d !== 8'h40) $display("FAIL wr_status got %h want 40", d); else n_pass++;
  endtask

  task automatic test_read_stop;
    logic [7:0] d; logic k, e; int n;
    slv_arm({8'h3C, 1'b1}, 0);
    wb_write(3'd4, 8'h28, 1);
    poll_tip(n);
    n_tot++; if (n != 180) $display("FAIL rd_tip_clocks got %0d want 180", n); else n_pass++;
    n_tot++; if (cap[0] !== 1'b1) $display("FAIL rd_nack_slot got %b want 1", cap[0]); else n_pass++;
    wb_read(3'd3, d, k, e);
    n_tot++; if (d !== 8'h3C) $display("FAIL rd_rxr got %h want 3c", d); else n_pass++;
    wb_write(3'd4, 8'h40, 1);
    poll_tip(n);
    n_tot++; if (n != 20) $display("FAIL stop_tip_clocks got %0d want 20", n); else n_pass++;
    wb_read(3'd4, d, k, e);
    n_tot++; if (d !== 8'h00) $display("FAIL stop_status got %h want 00", d); else n_pass++;
    n_tot++; if ({scl_oe, sda_oe} !== 2'b00) $display("FAIL stop_lines got %b want 00", {scl_oe, sda_oe}); else n_pass++;
  endtask

  task automatic test_stretch;
    int n;
    slv_arm(9'h1FE, 1);
    wb_write(3'd4, 8'h10, 1);
    poll_tip(n);
    n_tot++; if (n != 210) $display("FAIL stretch_tip_clocks got %0d want 210", n); else n_pass++;
    n_tot++; if ({hold_done, sda_chg} !== 2'b10) $display("FAIL stretch_sda_stable got %b want 10", {hold_done, sda_chg}); else n_pass++;
    n_tot++; if (cap !== 9'h14A) $display("FAIL stretch_sda_pattern got %h want 14a", cap); else n_pass++;
    slv_arm(9'h1FF, 0);
  endtask

  task automatic test_bus_rules;
    logic [7:0] d; logic k, e; int n;
    wb_read(3'd6, d, k, e);
    n_tot++; if ({e, k, d} !== 10'h200) $display("FAIL err_addr6 got %h want 200", {e, k, d}); else n_pass++;
    @(posedge clk); #1;
    n_tot++; if ({err, ack} !== 2'b00) $display("FAIL err_pulse_width got %b want 00", {err, ack}); else n_pass++;
    wb_write(3'd0, 8'h00, 1);
    wb_read(3'd0, d, k, e);
    n_tot++; if (d !== 8'h04) $display("FAIL prer_locked got %h want 04", d); else n_pass++;
    wb_write(3'd2, 8'h00, 0);
    n_tot++; if (ack !== 1'b1) $display("FAIL sel0_ack got %b want 1", ack); else n_pass++;
    wb_read(3'd2, d, k, e);
    n_tot++; if (d !== 8'h80) $display("FAIL sel0_noeffect got %h want 80", d); else n_pass++;
    slv_arm(9'h1FE, 0);
    wb_write(3'd4, 8'h10, 1);
    wb_write(3'd4, 8'hC0, 1);
    poll_tip(n);
    n_tot++; if (n != 179) $display("FAIL cmd_during_tip got %0d want 179", n); else n_pass++;
    wb_read(3'd4, d, k, e);
    n_tot++; if (d !== 8'h00) $display("FAIL cmd_ignored_status got %h want 00", d); else n_pass++;
  endtask

  task automatic test_async_reset;
    logic [7:0] d; logic k, e; bit seen;
    seen = 0;
    slv_arm(9'h1FE, 0);
    wb_write(3'd4, 8'h10, 1);
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (sda_oe) begin seen = 1; break; end
    end
    n_tot++; if (!seen) $display("FAIL arst_setup got sda_oe=0 want 1"); else n_pass++;
    #2 rst_n = 0;
    #1;
    n_tot++; if ({scl_oe, sda_oe} !== 2'b00) $display("FAIL arst_lines got %b want 00", {scl_oe, sda_oe}); else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1;
    wb_read(3'd0, d, k, e);
    n_tot++; if (d !== 8'h31) $display("FAIL arst_prer_lo got %h want 31", d); else n_pass++;
    wb_read(3'd1, d, k, e);
    n_tot++; if (d !== 8'h00) $display("FAIL arst_prer_hi got %h want 00", d); else n_pass++;
    wb_read(3'd2, d, k, e);
    n_tot++; if (d !== 8'h00) $display("FAIL arst_ctrl got %h want 00", d); else n_pass++;
    wb_read(3'd3, d, k, e);
    n_tot++; if (d !== 8'h00) $display("FAIL arst_rxr got %h want 00", d); else n_pass++;
    wb_read(3'd4, d, k, e);
    n_tot++; if (d !== 8'h00) $display("FAIL arst_status got %h want 00", d); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write_byte();
    test_read_stop();
    test_stretch();
    test_bus_rules();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
